// File: rtl/crtc_pkg.sv
// Shared definitions for the CRTC register sequencer: register map,
// power-on defaults and FSM encodings.
package crtc_pkg;

  localparam logic [1:0] REG_CURSOR_HI = 2'd0;
  localparam logic [1:0] REG_CURSOR_LO = 2'd1;
  localparam logic [1:0] REG_SCANLINES = 2'd2;
  localparam logic [1:0] REG_MODE      = 2'd3;

  // Scanline register default: cursor end line 14, start line 13.
  localparam logic [7:0] REG2_DEFAULT = 8'hED;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_STROBE   = 3'd2,
    ST_HOLD     = 3'd3,
    ST_IDLE     = 3'd4,
    ST_WAIT_VBL = 3'd5
  } state_e;

  typedef enum logic {
    SRC_INIT = 1'b0,
    SRC_HOST = 1'b1
  } src_e;

  // Cursor position lives in regs 0/1; writes there may tear the cursor mid-frame.
  function automatic logic is_cursor_reg(input logic [1:0] addr);
    return addr <= REG_CURSOR_LO;
  endfunction

endpackage

// File: rtl/crtc_reg_sequencer.sv
// Sole writer of the CRTC register file. Writes the four power-on defaults
// after reset, then turns host writes into timed address/data/n_write cycles,
// holding cursor-position writes back until vertical blanking.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// INIT     | load default for reg init_idx onto address/data
// SETUP    | address/data driven, n_write high, SETUP_CYCLES cycles
// STROBE   | n_write low, PULSE_CYCLES cycles
// HOLD     | n_write high again (register latched), address/data held 1 cycle
// IDLE     | waiting for host_req
// WAIT_VBL | cursor write captured, waiting for vblank before strobing
module crtc_reg_sequencer
  import crtc_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter bit          DEFER_CURSOR = 1'b1,
  parameter logic [7:0]  INIT_R0      = 8'h00,
  parameter logic [7:0]  INIT_R1      = 8'h00,
  parameter logic [7:0]  INIT_R2      = REG2_DEFAULT,
  parameter logic [7:0]  INIT_R3      = 8'h00
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       host_req,
  input  logic [1:0] host_addr,
  input  logic [7:0] host_data,
  output logic       host_ack,
  input  logic       vblank,
  output logic [1:0] rf_address,
  output logic [7:0] rf_data,
  output logic       rf_n_write,
  output logic       init_done,
  output logic       busy
);

  // Counter reload values: the counter expires after N cycles in its state.
  localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES - 1);

  state_e     state_q, state_d;
  src_e       src_q, src_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] init_idx_q, init_idx_d;
  logic [1:0] rf_address_q, rf_address_d;
  logic [7:0] rf_data_q, rf_data_d;
  logic       rf_n_write_q, rf_n_write_d;
  logic       host_ack_q, host_ack_d;
  logic       init_done_q, init_done_d;
  logic       busy_q, busy_d;
  logic [7:0] init_val;

  // Default value for the register currently being initialised.
  always_comb begin
    init_val = INIT_R0;
    case (init_idx_q)
      2'd0:    init_val = INIT_R0;
      2'd1:    init_val = INIT_R1;
      2'd2:    init_val = INIT_R2;
      default: init_val = INIT_R3;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    cnt_d        = cnt_q;
    init_idx_d   = init_idx_q;
    rf_address_d = rf_address_q;
    rf_data_d    = rf_data_q;
    rf_n_write_d = rf_n_write_q;
    host_ack_d   = 1'b0;
    init_done_d  = init_done_q;

    case (state_q)
      ST_INIT: begin
        rf_address_d = init_idx_q;
        rf_data_d    = init_val;
        src_d        = SRC_INIT;
        cnt_d        = SETUP_LOAD;
        state_d      = ST_SETUP;
      end
      ST_SETUP: begin
        rf_n_write_d = 1'b1;
        if (cnt_q == 4'd0) begin
          rf_n_write_d = 1'b0;
          cnt_d        = PULSE_LOAD;
          state_d      = ST_STROBE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          // Rising n_write here is the latch point; ack covers the HOLD cycle.
          rf_n_write_d = 1'b1;
          host_ack_d   = (src_q == SRC_HOST);
          state_d      = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        rf_n_write_d = 1'b1;
        if (src_q == SRC_INIT) begin
          if (init_idx_q == REG_MODE) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            state_d    = ST_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (host_req) begin
          rf_address_d = host_addr;
          rf_data_d    = host_data;
          src_d        = SRC_HOST;
          cnt_d        = SETUP_LOAD;
          if (DEFER_CURSOR && is_cursor_reg(host_addr) && !vblank) begin
            state_d = ST_WAIT_VBL;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end
      ST_WAIT_VBL: begin
        rf_n_write_d = 1'b1;
        // Once launched the write runs to completion even if vblank ends.
        if (vblank) begin
          cnt_d   = SETUP_LOAD;
          state_d = ST_SETUP;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q      <= ST_INIT;
      src_q        <= SRC_INIT;
      cnt_q        <= 4'd0;
      init_idx_q   <= 2'd0;
      rf_address_q <= 2'd0;
      rf_data_q    <= 8'd0;
      rf_n_write_q <= 1'b1;
      host_ack_q   <= 1'b0;
      init_done_q  <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      cnt_q        <= cnt_d;
      init_idx_q   <= init_idx_d;
      rf_address_q <= rf_address_d;
      rf_data_q    <= rf_data_d;
      rf_n_write_q <= rf_n_write_d;
      host_ack_q   <= host_ack_d;
      init_done_q  <= init_done_d;
      busy_q       <= busy_d;
    end
  end

  assign rf_address = rf_address_q;
  assign rf_data    = rf_data_q;
  assign rf_n_write = rf_n_write_q;
  assign host_ack   = host_ack_q;
  assign init_done  = init_done_q;
  assign busy       = busy_q;

endmodule
